winograd_ewmm_accum: RTL and testbench
======================================

Name: winograd_ewmm_accum

Overview:
Element-wise multiply-accumulate stage of the Winograd F(4x4,3x3) convolution datapath.
- Takes one transformed input tile U (6x6) and one transformed kernel tile V (6x6) per input channel.
- Accumulates M += U ⊙ V over a programmable number of channels.
- Presents the 6x6 result M to the output reverse-transform stage, with a one-cycle done pulse that drives that stage's start.

Parameters:
- DATA_WIDTH, 32, width of every U, V and accumulator element (signed two's complement).
- CH_WIDTH, 8, width of the channel-count port.

Ports:
- clk  input  1  clock.
- rst_n  input  1  reset; asynchronous, active-low.
- start  input  1  begin a new accumulation; sampled only in S_IDLE.
- num_channels  input  CH_WIDTH  number of channel tiles to accumulate; latched on start.
- in_valid  input  1  tile_u/tile_v hold a valid channel pair.
- in_ready  output  1  block will accept a pair this cycle.
- tile_u  input  DATA_WIDTH x [0:5][0:5]  transformed input tile.
- tile_v  input  DATA_WIDTH x [0:5][0:5]  transformed kernel tile.
- matrix_out  output  DATA_WIDTH x [0:5][0:5]  accumulated result M; held stable until the next done.
- done  output  1  one-cycle pulse; matrix_out is valid from this cycle.
- busy  output  1  high in every state except S_IDLE.

Behaviour:
- Reset values: in_ready=0, done=0, busy=0, matrix_out all 0, accumulator all 0, operand registers all 0, channel counter 0, state S_IDLE.
- Reset is effective mid-operation; no partial result survives it.

States:
- S_IDLE:
  - On start: clear the accumulator and latch num_channels into the remaining-channel counter.
  - If num_channels==0 go to S_DONE, otherwise go to S_WAIT.
  - start in any other state is ignored.
- S_WAIT:
  - in_ready=1 (registered, so it is high from the first cycle in S_WAIT).
  - On an edge with in_valid && in_ready: copy tile_u and tile_v into operand registers, go to S_MAC with row index 0.
  - Without in_valid the block stays in S_WAIT indefinitely; nothing else changes.
- S_MAC:
  - in_ready=0.
  - One row per cycle: acc[r][c] <= acc[r][c] + opU[r][c]*opV[r][c] for c=0..5, using 6 multipliers.
  - Row index runs 0..5.
  - After row 5, decrement the counter. If the result is 0, go to S_DONE; otherwise return to S_WAIT.
- S_DONE:
  - On entry edge: matrix_out <= acc and done <= 1.
  - Next cycle: done <= 0, state returns to S_IDLE.
  - done is high for exactly one cycle; matrix_out is unchanged after that.
  - For num_channels==0, matrix_out becomes all zeros.

Arithmetic:
- Signed DATA_WIDTH x DATA_WIDTH multiply to a 2*DATA_WIDTH product.
- Without the optional feature: keep the low DATA_WIDTH bits of the product and add modulo 2^DATA_WIDTH (wrap-around), matching the downstream transform's modulo arithmetic.

Timing:
- Per channel: accept edge, then 6 MAC cycles.
- With in_valid held high, consecutive accepts are 7 cycles apart.
- done rises 1 cycle after the final row-5 MAC edge.
- Total latency from start to done with continuous input: 1 + 7*N + 1 cycles.

Other rules:
- matrix_out changes only at done; it never shows partial sums.
- tile_u and tile_v may change freely after the accept edge.

Optional Feature:
- Macro: WINOGRAD_EWMM_SAT_EN.
- Defined:
  - Products are kept at full 2*DATA_WIDTH width.
  - Each accumulate is computed at 2*DATA_WIDTH+1 bits and saturated to the signed DATA_WIDTH range [-2^(DATA_WIDTH-1), 2^(DATA_WIDTH-1)-1] before being stored.
  - An additional output sat_flag (1 bit) is set if any element saturated during the accumulation. It is cleared on start and valid with done.
- Not defined: wrap-around arithmetic as above, and no sat_flag port exists.

Test Plan:
1. num_channels=1, all U=2, all V=3, in_valid held high -> done pulses exactly 9 cycles after the start edge; all 36 outputs = 6; in_ready low for 6 cycles after accept.
2. num_channels=3, U[r][c]=r, V[r][c]=c, same pair each channel -> matrix_out[r][c]=3*r*c (e.g. [5][5]=75, [0][x]=0); exactly 3 accepts observed.
3. num_channels=0 -> in_ready never asserts; done pulses 1 cycle after start; matrix_out all 0 even if the prior result was non-zero.
4. num_channels=2, in_valid withheld 10 cycles before the second pair, U=-4, V=5 -> state holds in S_WAIT with in_ready=1; final outputs all -40 (0xFFFFFFD8); start pulsed mid-run is ignored.
5. num_channels=1, U=V=0x00010000 -> without the macro, outputs 0x00000000; with WINOGRAD_EWMM_SAT_EN, outputs 0x7FFFFFFF and sat_flag=1.
6. rst_n low during MAC row 3 of a num_channels=2 run -> immediately in_ready=0, done=0, busy=0, matrix_out all 0; a fresh run after release yields correct results.

Source files
------------

// File: rtl/winograd_ewmm_accum.sv
// Winograd F(4x4,3x3) element-wise multiply-accumulate: M += U .* V over N channel tiles.
// Optional macro WINOGRAD_EWMM_SAT_EN: full-width products, saturating accumulate, sat_flag output.
module winograd_ewmm_accum #(
  parameter int DATA_WIDTH = 32,
  parameter int CH_WIDTH   = 8
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            start,
  input  logic [CH_WIDTH-1:0]             num_channels,
  input  logic                            in_valid,
  output logic                            in_ready,
  input  logic [0:5][0:5][DATA_WIDTH-1:0] tile_u,
  input  logic [0:5][0:5][DATA_WIDTH-1:0] tile_v,
  output logic [0:5][0:5][DATA_WIDTH-1:0] matrix_out,
  output logic                            done,
`ifdef WINOGRAD_EWMM_SAT_EN
  output logic                            sat_flag,
`endif
  output logic                            busy
);

`ifdef WINOGRAD_EWMM_SAT_EN
  localparam int PW = 2 * DATA_WIDTH;
`else
  localparam int PW = DATA_WIDTH;
`endif

  typedef logic [0:5][0:5][DATA_WIDTH-1:0] tile_t;
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_MAC  = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t              state_q, state_d;
  logic [CH_WIDTH-1:0] cnt_q, cnt_d;
  logic [2:0]          row_q, row_d;
  tile_t               acc_q, acc_d;
  tile_t               opu_q, opu_d;
  tile_t               opv_q, opv_d;
  tile_t               mout_q, mout_d;
  logic                done_q, done_d;
  logic                in_ready_q, in_ready_d;
  logic                busy_q, busy_d;
  logic [PW-1:0]         prod_s [0:5];
  logic [DATA_WIDTH-1:0] sum_s  [0:5];
`ifdef WINOGRAD_EWMM_SAT_EN
  logic                sat_q, sat_d;
  logic [5:0]          sat_s;
`endif

  // Sign-extend both operands to PW bits; the low PW bits of the product are the signed product.
  function automatic logic [PW-1:0] mul_ext(input logic [DATA_WIDTH-1:0] a,
                                            input logic [DATA_WIDTH-1:0] b);
    logic [PW-1:0] ax;
    logic [PW-1:0] bx;
    ax = PW'($signed(a));
    bx = PW'($signed(b));
    return ax * bx;
  endfunction

`ifdef WINOGRAD_EWMM_SAT_EN
  // Returns {saturated, value}: sum at PW+1 bits clamped to the signed DATA_WIDTH range.
  function automatic logic [DATA_WIDTH:0] sat_add(input logic [DATA_WIDTH-1:0] a,
                                                  input logic [PW-1:0] p);
    logic [PW:0] s;
    s = {{(PW + 1 - DATA_WIDTH){a[DATA_WIDTH-1]}}, a} + {p[PW-1], p};
    if ((s[PW:DATA_WIDTH-1] == '0) || (s[PW:DATA_WIDTH-1] == '1)) begin
      return {1'b0, s[DATA_WIDTH-1:0]};
    end else if (s[PW]) begin
      return {1'b1, 1'b1, {(DATA_WIDTH-1){1'b0}}};
    end else begin
      return {1'b1, 1'b0, {(DATA_WIDTH-1){1'b1}}};
    end
  endfunction
`endif

  // Six lanes: one row of products and updated partial sums per cycle.
  always_comb begin
    for (int c = 0; c < 6; c++) begin
      prod_s[c] = mul_ext(opu_q[row_q][c], opv_q[row_q][c]);
`ifdef WINOGRAD_EWMM_SAT_EN
      {sat_s[c], sum_s[c]} = sat_add(acc_q[row_q][c], prod_s[c]);
`else
      sum_s[c] = acc_q[row_q][c] + prod_s[c];
`endif
    end
  end

  // Next-state and datapath control.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    row_d   = row_q;
    acc_d   = acc_q;
    opu_d   = opu_q;
    opv_d   = opv_q;
    mout_d  = mout_q;
    done_d  = 1'b0;
`ifdef WINOGRAD_EWMM_SAT_EN
    sat_d   = sat_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (start) begin
          acc_d   = '0;
          cnt_d   = num_channels;
`ifdef WINOGRAD_EWMM_SAT_EN
          sat_d   = 1'b0;
`endif
          state_d = (num_channels == '0) ? S_DONE : S_WAIT;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_WAIT: begin
        if (in_valid && in_ready_q) begin
          opu_d   = tile_u;
          opv_d   = tile_v;
          row_d   = 3'd0;
          state_d = S_MAC;
        end else begin
          state_d = S_WAIT;
        end
      end
      S_MAC: begin
        for (int c = 0; c < 6; c++) begin
          acc_d[row_q][c] = sum_s[c];
        end
`ifdef WINOGRAD_EWMM_SAT_EN
        sat_d = sat_q | (|sat_s);
`endif
        if (row_q == 3'd5) begin
          row_d   = 3'd0;
          cnt_d   = cnt_q - CH_WIDTH'(1);
          state_d = (cnt_q == CH_WIDTH'(1)) ? S_DONE : S_WAIT;
        end else begin
          row_d = row_q + 3'd1;
        end
      end
      S_DONE: begin
        mout_d  = acc_q;
        done_d  = 1'b1;
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
    // Handshake/status outputs are registered from the next state so they track the state register.
    in_ready_d = (state_d == S_WAIT);
    busy_d     = (state_d != S_IDLE);
  end

  // State and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      row_q      <= 3'd0;
      acc_q      <= '0;
      opu_q      <= '0;
      opv_q      <= '0;
      mout_q     <= '0;
      done_q     <= 1'b0;
      in_ready_q <= 1'b0;
      busy_q     <= 1'b0;
`ifdef WINOGRAD_EWMM_SAT_EN
      sat_q      <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      row_q      <= row_d;
      acc_q      <= acc_d;
      opu_q      <= opu_d;
      opv_q      <= opv_d;
      mout_q     <= mout_d;
      done_q     <= done_d;
      in_ready_q <= in_ready_d;
      busy_q     <= busy_d;
`ifdef WINOGRAD_EWMM_SAT_EN
      sat_q      <= sat_d;
`endif
    end
  end

  assign in_ready   = in_ready_q;
  assign done       = done_q;
  assign busy       = busy_q;
  assign matrix_out = mout_q;
`ifdef WINOGRAD_EWMM_SAT_EN
  assign sat_flag   = sat_q;
`endif

endmodule

// File: tb/tb_winograd_ewmm_accum.sv
// Scoreboard bench for winograd_ewmm_accum: stimulus pushes reference results, a monitor pops them on done.
module tb_winograd_ewmm_accum;
  typedef logic [0:5][0:5][31:0] mat_t;
  typedef struct {
    mat_t m;
    bit   sat;
    int   start_cyc;
    int   lat;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst_n, start, in_valid, in_ready, done, busy;
  logic [7:0] num_channels;
  mat_t       tile_u, tile_v, matrix_out;
`ifdef WINOGRAD_EWMM_SAT_EN
  logic       sat_flag;
`endif

  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   accepts = 0;
  int   dones = 0;
  exp_t exp_q[$];

  winograd_ewmm_accum #(.DATA_WIDTH(32), .CH_WIDTH(8)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .num_channels(num_channels),
    .in_valid(in_valid), .in_ready(in_ready), .tile_u(tile_u), .tile_v(tile_v),
    .matrix_out(matrix_out), .done(done),
`ifdef WINOGRAD_EWMM_SAT_EN
    .sat_flag(sat_flag),
`endif
    .busy(busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  function automatic mat_t gen(input int mode, input bit isv);
    mat_t m;
    int   x;
    for (int r = 0; r < 6; r++) begin
      for (int c = 0; c < 6; c++) begin
        case (mode)
          1: m[r][c] = isv ? 32'd3 : 32'd2;
          2: m[r][c] = isv ? 32'(c) : 32'(r);
          3: m[r][c] = isv ? 32'd5 : 32'hFFFF_FFFC;
          4: m[r][c] = 32'h0001_0000;
          5: begin
            x = int'($urandom_range(200)) - 100;
            m[r][c] = x;
          end
          default: m[r][c] = $urandom();
        endcase
      end
    end
    return m;
  endfunction

  // Reference: plain integer sum of element products over channels (wrapping, or clamped per step).
  task automatic model(input mat_t us[$], input mat_t vs[$], output mat_t m, output bit sat);
    int     acc, u, v;
    longint s;
    sat = 1'b0;
    for (int r = 0; r < 6; r++) begin
      for (int c = 0; c < 6; c++) begin
        acc = 0;
        for (int k = 0; k < us.size(); k++) begin
          u = us[k][r][c];
          v = vs[k][r][c];
`ifdef WINOGRAD_EWMM_SAT_EN
          s = longint'(acc) + longint'(u) * longint'(v);
          if (s > 64'sd2147483647) begin
            acc = 32'h7FFF_FFFF;
            sat = 1'b1;
          end else if (s < -64'sd2147483648) begin
            acc = 32'h8000_0000;
            sat = 1'b1;
          end else begin
            acc = int'(s);
          end
`else
          s = 0;
          acc = acc + u * v;
`endif
        end
        m[r][c] = acc;
      end
    end
  endtask

  // Monitor: pops the scoreboard whenever done is seen and checks that matrix_out otherwise holds.
  initial begin
    exp_t e;
    mat_t held;
    logic done_prev;
    int   nbad, br, bc;
    held = '0;
    done_prev = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        held = '0;
        done_prev = 1'b0;
      end else begin
        if (in_valid && in_ready) accepts++;
        if (done) begin
          check("done_one_cycle", done_prev, 0);
          if (exp_q.size() == 0) begin
            check("done_unexpected", 1, 0);
          end else begin
            e = exp_q.pop_front();
            nbad = 0; br = 0; bc = 0;
            for (int r = 0; r < 6; r++) begin
              for (int c = 0; c < 6; c++) begin
                if (matrix_out[r][c] !== e.m[r][c]) begin
                  if (nbad == 0) begin br = r; bc = c; end
                  nbad++;
                end
              end
            end
            checks++;
            if (nbad != 0) begin
              errors++;
              $display("FAIL matrix_out[%0d][%0d]: got %h, expected %h (%0d elements differ)",
                       br, bc, matrix_out[br][bc], e.m[br][bc], nbad);
            end
            check("done_latency", cyc - e.start_cyc, e.lat);
`ifdef WINOGRAD_EWMM_SAT_EN
            check("sat_flag", sat_flag, e.sat);
`endif
          end
          held = matrix_out;
          dones++;
        end else begin
          check("matrix_out_hold", matrix_out === held, 1);
        end
        done_prev = done;
      end
    end
  end

  task automatic wait_idle();
    int t;
    t = 0;
    while (busy && t < 200) begin
      @(negedge clk);
      t++;
    end
    check("idle_before_start", busy, 0);
  endtask

  // One accumulation job; gap withholds the second pair for 10 cycles and pulses start meanwhile.
  task automatic run_job(input int n, input int mode, input bit gap);
    mat_t us[$], vs[$];
    mat_t m;
    bit   sat, saw;
    exp_t e;
    int   t, a0, d0, sc;
    for (int k = 0; k < n; k++) begin
      us.push_back(gen(mode, 1'b0));
      vs.push_back(gen(mode, 1'b1));
    end
    model(us, vs, m, sat);
    wait_idle();
    a0 = accepts;
    d0 = dones;
    @(posedge clk); #1;
    sc = cyc;  // start is driven here; done is due 1 + 7N + 1 edges later
    start = 1'b1;
    num_channels = n[7:0];
    if (n > 0) begin
      tile_u = us[0];
      tile_v = vs[0];
      in_valid = 1'b1;
    end
    @(posedge clk); #1;
    start = 1'b0;
    e.m = m;
    e.sat = sat;
    e.start_cyc = sc;
    e.lat = 7 * n + 2 + (gap ? 10 : 0);
    exp_q.push_back(e);
    saw = in_ready;
    for (int k = 0; k < n; k++) begin
      if (gap && k == 1) begin
        t = 0;
        while (!in_ready && t < 50) begin @(negedge clk); t++; end
        check("gap_reach_wait", in_ready, 1);
        for (int g = 0; g < 10; g++) begin
          @(posedge clk); #1;
          start = (g == 2);
          if (g == 2) num_channels = 8'd0;
          if (g == 9) begin
            tile_u = us[k];
            tile_v = vs[k];
            in_valid = 1'b1;
          end
          @(negedge clk);
          check("gap_wait_hold", in_ready && busy, 1);
        end
        start = 1'b0;
      end
      t = 0;
      while (!(in_ready && in_valid) && t < 50) begin @(negedge clk); t++; end
      check("accept_ready", in_ready && in_valid, 1);
      @(posedge clk); #1;
      if (k + 1 < n && !(gap && k + 1 == 1)) begin
        tile_u = us[k + 1];
        tile_v = vs[k + 1];
        in_valid = 1'b1;
      end else begin
        in_valid = 1'b0;
        tile_u = gen(0, 1'b0);
        tile_v = gen(0, 1'b1);
      end
      saw = 1'b0;
      for (int i = 0; i < 6; i++) begin
        @(negedge clk);
        if (in_ready || !busy) saw = 1'b1;
      end
      check("mac_in_ready_low", saw, 0);
    end
    t = 0;
    while (dones == d0 && t < 100) begin
      @(negedge clk);
      if (in_ready) saw = 1'b1;
      t++;
    end
    check("done_seen", dones - d0, 1);
    check("accept_count", accepts - a0, n);
    if (n == 0) check("zero_ch_no_ready", saw, 0);
  endtask

  initial begin
    int a0, n;
    rst_n = 1'b0;
    start = 1'b0;
    in_valid = 1'b0;
    num_channels = 8'd0;
    tile_u = '0;
    tile_v = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_in_ready", in_ready, 0);
    check("rst_done", done, 0);
    check("rst_busy", busy, 0);
    check("rst_matrix_zero", matrix_out == '0, 1);
    rst_n = 1'b1;

    run_job(1, 1, 1'b0);   // all 6
    run_job(3, 2, 1'b0);   // 3*r*c
    run_job(0, 0, 1'b0);   // zeros after non-zero result
    run_job(2, 3, 1'b1);   // -40 with stall and ignored start
    run_job(1, 4, 1'b0);   // 2^16 * 2^16
    for (int i = 0; i < 6; i++) begin
      n = int'($urandom_range(1, 4));
      run_job(n, (i % 2 == 0) ? 5 : 0, (i == 3) && (n >= 2));
    end

    // Asynchronous reset during MAC row 3 of a two-channel run.
    wait_idle();
    a0 = accepts;
    @(posedge clk); #1;
    start = 1'b1;
    num_channels = 8'd2;
    tile_u = gen(5, 1'b0);
    tile_v = gen(5, 1'b1);
    in_valid = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    check("pre_reset_accept", accepts - a0, 1);
    rst_n = 1'b0;
    #1;
    check("midrst_in_ready", in_ready, 0);
    check("midrst_done", done, 0);
    check("midrst_busy", busy, 0);
    check("midrst_matrix_zero", matrix_out == '0, 1);
    @(posedge clk); #1;
    rst_n = 1'b1;
    run_job(3, 0, 1'b0);

    repeat (3) @(posedge clk);
    check("scoreboard_empty", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
